dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning access latency in cycles (legal range 1..15).
REQ-002 SHALL have parameter LINE_AW, default 8, meaning log2 of the number of 128-bit lines stored.
REQ-003 SHALL have port clk, input, 1, the rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req, input, 1, the cache line request, held by the cache until done.
REQ-006 SHALL have port wr, input, 1, request type: 1 = line write-back, 0 = line fill.
REQ-007 SHALL have port daddr, input, 20, the byte address; line index is daddr[LINE_AW+3:4].
REQ-008 SHALL have port dirty_data, input, 128, the write-back line; word k is bits [32k+31:32k].
REQ-009 SHALL have port data_i, output, 32, the fill beat data.
REQ-010 SHALL have port valid, output, 1, qualifying data_i.
REQ-011 SHALL have port rd_done, output, 1, a one-cycle fill-complete pulse.
REQ-012 SHALL have port wr_done, output, 1, a one-cycle write-back-complete pulse.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, BEAT, RELEASE.
REQ-014 In IDLE with req=1 at edge T, the block SHALL capture wr, daddr and dirty_data and enter WAIT; inputs are ignored outside IDLE.
REQ-015 WAIT SHALL last exactly LAT cycles (T+1..T+LAT), tracked by a down-counter of width clog2(LAT+1).
REQ-016 On write: the line SHALL be written to the array at the end of cycle T+LAT, wr_done=1 in cycle T+LAT+1 only, then the FSM enters RELEASE.
REQ-017 On read: the FSM SHALL enter BEAT; valid=1 in cycles T+LAT+1..T+LAT+4, each cycle carrying one word of the line; a beat counter of 2 bits SHALL wrap modulo 4.
REQ-018 On read: rd_done=1 in cycle T+LAT+5 only, then the FSM enters RELEASE.
REQ-019 RELEASE SHALL return to IDLE on the first cycle with req=0, so that a held req never retriggers.
REQ-020 Address bits above LINE_AW+3 SHALL be ignored (aliasing); bits [1:0] SHALL always be ignored.
REQ-021 A read of a line SHALL return the most recent write-back to the same line index.
REQ-022 data_i SHALL be 0 whenever valid=0.
REQ-023 valid, rd_done and wr_done SHALL never be high in the same cycle.

Reset
REQ-024 With reset_n=0 at an edge, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-025 Reset SHALL force data_i=0, valid=0, rd_done=0 and wr_done=0.
REQ-026 A reset mid-operation SHALL abort it: no done pulse is issued, and any write not yet committed is dropped.
REQ-027 Array contents SHALL NOT be reset; the simulation initial value is all zeros.

Configuration
REQ-028 The macro DMEM_CRITICAL_WORD_FIRST_EN SHALL select the fill beat order.
REQ-029 When DMEM_CRITICAL_WORD_FIRST_EN is defined, beats SHALL start at word daddr[3:2] and wrap (for example 2,3,0,1).
REQ-030 When DMEM_CRITICAL_WORD_FIRST_EN is undefined, beats SHALL always be in order 0,1,2,3.
REQ-031 Write-back ordering SHALL be unaffected by DMEM_CRITICAL_WORD_FIRST_EN.

Structure
REQ-032 Package dmem_pkg SHALL hold the FSM state encoding, the line width constant (128), the word width constant (32) and the beat count (4).
REQ-033 The storage SHALL be the sub-module dmem_array: single-port, 2^LINE_AW x 128, synchronous write, combinational read, with word select outside the array.

Verification
REQ-034 Bench SHALL cover: write daddr=0x00100, dirty_data=0x4444_4444_3333_3333_2222_2222_1111_1111 with LAT=4 -> wr_done pulses in T+5 only.
REQ-035 Bench SHALL cover: read daddr=0x00100 after that write, macro undefined -> valid in T+5..T+8 carrying 0x11111111, 0x22222222, 0x33333333, 0x44444444; rd_done in T+9.
REQ-036 Bench SHALL cover: same read with DMEM_CRITICAL_WORD_FIRST_EN defined and daddr=0x00108 -> beats 0x33333333, 0x44444444, 0x11111111, 0x22222222.
REQ-037 Bench SHALL cover: req held high for 10 cycles after rd_done -> no new valid and no second done until req drops and rises again.
REQ-038 Bench SHALL cover: reset_n=0 during the second beat -> next cycle all outputs are 0, no rd_done, and a following request behaves normally.
REQ-039 Bench SHALL cover: with LINE_AW=8, a write to daddr=0x01100 followed by a read from daddr=0x00100 -> the read returns the aliased line.

Source files
------------

// File: rtl/dmem_pkg.sv
// +-----------------------------------------------------------------+
// | dmem_pkg: shared state encoding, widths and word-select helper  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_BEAT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [$clog2(BEATS)-1:0] idx);
    return line[idx*WORD_W +: WORD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +-----------------------------------------------------------------+
// | dmem_array: single-port line store, sync write, comb read       |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int LINE_AW = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LINE_AW-1:0] addr,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);

  // Contents are intentionally not reset.
  logic [LINE_W-1:0] mem_q [2**LINE_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/dmem_resp.sv
// +-----------------------------------------------------------------+
// | dmem_resp: fixed-latency line fill / write-back responder       |
// | Option: DMEM_CRITICAL_WORD_FIRST_EN (fill starts at daddr[3:2]) |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module dmem_resp
  import dmem_pkg::*;
#(
  parameter int LAT     = 4,
  parameter int LINE_AW = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  input  logic         wr,
  input  logic [19:0]  daddr,
  input  logic [127:0] dirty_data,
  output logic [31:0]  data_i,
  output logic         valid,
  output logic         rd_done,
  output logic         wr_done
);

  localparam int CNT_W = $clog2(LAT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          beat_q, beat_d;
  logic [1:0]          start_q, start_d;
  logic                wr_q, wr_d;
  logic [LINE_AW-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0]   dirty_q, dirty_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                rd_done_q, rd_done_d;
  logic                wr_done_q, wr_done_d;
  logic                arr_we;
  logic [LINE_W-1:0]   arr_rdata;
  logic                addr_unused;

  assign addr_unused = ^{daddr[19:LINE_AW+4], daddr[1:0]};

  dmem_array #(.LINE_AW(LINE_AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (idx_q),
    .wdata (dirty_q),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    start_d   = start_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q;
    data_d    = '0;
    valid_d   = 1'b0;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    arr_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          wr_d    = wr;
          idx_d   = daddr[LINE_AW+3:4];
          dirty_d = dirty_data;
`ifdef DMEM_CRITICAL_WORD_FIRST_EN
          start_d = daddr[3:2];
`else
          start_d = 2'd0;
`endif
          cnt_d   = CNT_W'(LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          if (wr_q) begin
            // Gated so a reset in the commit cycle drops the write.
            arr_we    = reset_n;
            wr_done_d = 1'b1;
            state_d   = ST_RELEASE;
          end else begin
            valid_d = 1'b1;
            data_d  = get_word(arr_rdata, start_q);
            beat_d  = start_q + 2'd1;
            state_d = ST_BEAT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BEAT: begin
        // Beat index wrapping back to the start word means all four are out.
        if (beat_q == start_q) begin
          rd_done_d = 1'b1;
          beat_d    = 2'd0;
          state_d   = ST_RELEASE;
        end else begin
          valid_d = 1'b1;
          data_d  = get_word(arr_rdata, beat_q);
          beat_d  = beat_q + 2'd1;
        end
      end
      ST_RELEASE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      start_q   <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      dirty_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      start_q   <= start_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign data_i  = data_q;
  assign valid   = valid_q;
  assign rd_done = rd_done_q;
  assign wr_done = wr_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_resp.sv
// +-----------------------------------------------------------------+
// | tb_dmem_resp: directed self-checking bench for dmem_resp        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_dmem_resp;

  localparam int LAT     = 4;
  localparam int LINE_AW = 8;

  localparam logic [127:0] LINE_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] LINE_B = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
  localparam logic [127:0] LINE_C = 128'h0C0C_0C04_0C0C_0C03_0C0C_0C02_0C0C_0C01;
  localparam logic [127:0] LINE_D = 128'hD0D0_D004_D0D0_D003_D0D0_D002_D0D0_D001;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req = 1'b0;
  logic         wr = 1'b0;
  logic [19:0]  daddr = '0;
  logic [127:0] dirty_data = '0;
  logic [31:0]  data_i;
  logic         valid;
  logic         rd_done;
  logic         wr_done;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  dmem_resp #(.LAT(LAT), .LINE_AW(LINE_AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .wr         (wr),
    .daddr      (daddr),
    .dirty_data (dirty_data),
    .data_i     (data_i),
    .valid      (valid),
    .rd_done    (rd_done),
    .wr_done    (wr_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"},   {31'd0, valid},   32'd0);
    chk({tag, ".data_i"},  data_i,           32'd0);
    chk({tag, ".rd_done"}, {31'd0, rd_done}, 32'd0);
    chk({tag, ".wr_done"}, {31'd0, wr_done}, 32'd0);
  endtask

  // One full transaction from IDLE; checks every output in cycles T+1..done.
  // With hold=1 req stays high after the done pulse.
  task automatic xact(input string tag, input logic w, input logic [19:0] a,
                      input logic [127:0] d, input logic [127:0] exp_line,
                      input logic hold);
    logic [1:0]  s;
    logic [1:0]  wi;
    logic        ev;
    logic [31:0] ed;
    int          last;
    req        = 1'b1;
    wr         = w;
    daddr      = a;
    dirty_data = d;
    s = 2'd0;
`ifdef DMEM_CRITICAL_WORD_FIRST_EN
    s = a[3:2];
`endif
    last = w ? LAT + 1 : LAT + 5;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      ev = !w && (i >= LAT + 1) && (i <= LAT + 4);
      wi = s + 2'(i - LAT - 1);
      ed = ev ? exp_line[wi*32 +: 32] : 32'd0;
      chk($sformatf("%s.c%0d.valid", tag, i),   {31'd0, valid},   {31'd0, ev});
      chk($sformatf("%s.c%0d.data_i", tag, i),  data_i,           ed);
      chk($sformatf("%s.c%0d.rd_done", tag, i), {31'd0, rd_done}, {31'd0, (!w && i == last)});
      chk($sformatf("%s.c%0d.wr_done", tag, i), {31'd0, wr_done}, {31'd0, (w && i == last)});
    end
    if (!hold) begin
      req = 1'b0;
      @(negedge clk);
      chk_idle({tag, ".after"});
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Write-back, then in-order / critical-word fills of the same line
    xact("wr_a", 1'b1, 20'h00100, LINE_A, '0, 1'b0);
    xact("rd_a0", 1'b0, 20'h00100, '0, LINE_A, 1'b0);
    xact("rd_a8", 1'b0, 20'h00108, '0, LINE_A, 1'b0);
    xact("rd_ab", 1'b0, 20'h0010B, '0, LINE_A, 1'b0);

    // Held req after rd_done must not retrigger
    xact("rd_hold", 1'b0, 20'h00100, '0, LINE_A, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle($sformatf("hold.c%0d", i));
    end
    req = 1'b0;
    @(negedge clk);
    chk_idle("hold.drop");
    xact("rd_rerise", 1'b0, 20'h00100, '0, LINE_A, 1'b0);

    // Reset during the second beat aborts the fill
    req   = 1'b1;
    wr    = 1'b0;
    daddr = 20'h00100;
    for (int i = 1; i <= LAT + 2; i++) @(negedge clk);
    chk("rst_beat.valid", {31'd0, valid}, 32'd1);
    chk("rst_beat.data_i", data_i, 32'h2222_2222);
    reset_n = 1'b0;
    req     = 1'b0;
    @(negedge clk);
    chk_idle("rst_beat.next");
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst_beat.quiet%0d", i));
    end
    xact("rd_after_rst", 1'b0, 20'h00100, '0, LINE_A, 1'b0);

    // Aliasing: bit 12 is above the index and must be ignored
    xact("wr_alias", 1'b1, 20'h01100, LINE_B, '0, 1'b0);
    xact("rd_alias", 1'b0, 20'h00100, '0, LINE_B, 1'b0);

    // Reset in the commit cycle drops the write-back and its done pulse
    xact("wr_c", 1'b1, 20'h00200, LINE_C, '0, 1'b0);
    req        = 1'b1;
    wr         = 1'b1;
    daddr      = 20'h00200;
    dirty_data = LINE_D;
    for (int i = 1; i <= LAT; i++) @(negedge clk);
    reset_n = 1'b0;
    req     = 1'b0;
    @(negedge clk);
    chk_idle("rst_wr.next");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst_wr.quiet%0d", i));
    end
    xact("rd_c", 1'b0, 20'h00200, '0, LINE_C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
